// File: rtl/stat_pkg.sv
// Shared types and default widths for the flow-statistics block and its read arbiter.
package stat_pkg;

  localparam int unsigned StatAWidth = 3;
  localparam int unsigned StatDWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } stat_rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  // One spare bit so ptr + offset can exceed N before the wrap subtraction.
  logic [IdxW:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IdxW + 1)'(k);
      if (pos >= (IdxW + 1)'(N)) begin
        pos = pos - (IdxW + 1)'(N);
      end
      if (!found && req_i[pos[IdxW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[pos[IdxW-1:0]]   = 1'b1;
        idx_o                  = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/stat_rd_arb.sv
// Shares the single stat_pkt read port among N_REQ requesters: round-robin,
// one read in flight, timeout-protected. All outputs registered.
module stat_rd_arb
  import stat_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned A_WIDTH = StatAWidth,
  parameter int unsigned D_WIDTH = StatDWidth,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*A_WIDTH-1:0]   req_flow_num_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           rsp_val_o,
  output logic [D_WIDTH-1:0]         rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       busy_o,
  output logic                       stat_rd_stb_o,
  output logic [A_WIDTH-1:0]         stat_rd_flow_num_o,
  input  logic [D_WIDTH-1:0]         stat_rd_data_i,
  input  logic                       stat_rd_data_val_i
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  stat_rd_state_e   state_q;
  logic [IdxW-1:0]  ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic [N_REQ-1:0] win_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic [A_WIDTH-1:0] arb_flow;
  logic [CntW-1:0]    cnt_nxt;
  logic [IdxW-1:0]    ptr_nxt;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign arb_flow = req_flow_num_i[arb_idx*A_WIDTH +: A_WIDTH];
  assign cnt_nxt  = cnt_q + 1'b1;
  assign ptr_nxt  = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q            <= StIdle;
      ptr_q              <= '0;
      cnt_q              <= '0;
      win_q              <= '0;
      gnt_o              <= '0;
      rsp_val_o          <= '0;
      rsp_data_o         <= '0;
      rsp_err_o          <= 1'b0;
      busy_o             <= 1'b0;
      stat_rd_stb_o      <= 1'b0;
      stat_rd_flow_num_o <= '0;
    end else begin
      gnt_o         <= '0;
      rsp_val_o     <= '0;
      stat_rd_stb_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            state_q            <= StIssue;
            gnt_o              <= arb_gnt;
            win_q              <= arb_gnt;
            stat_rd_stb_o      <= 1'b1;
            stat_rd_flow_num_o <= arb_flow;
            busy_o             <= 1'b1;
            ptr_q              <= ptr_nxt;
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          cnt_q <= cnt_nxt;
          // Data beats the timeout when both land on the same cycle.
          if (stat_rd_data_val_i) begin
            state_q    <= StResp;
            rsp_val_o  <= win_q;
            rsp_data_o <= stat_rd_data_i;
            rsp_err_o  <= 1'b0;
          end else if (cnt_nxt == CntW'(TIMEOUT - 1)) begin
            state_q    <= StResp;
            rsp_val_o  <= win_q;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
          end
        end
        StResp: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
